// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice: op codes, FSM states
// and a clog2 helper used to size requester indices.
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF   = 3;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Index width for v items, never below 1 bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans req_i upward from ptr_i, wrapping,
// and returns a one-hot grant plus the winner index.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]           req_i,
  input  logic [clog2(N)-1:0]    ptr_i,
  output logic [N-1:0]           grant_o,
  output logic [clog2(N)-1:0]    idx_o,
  output logic                   any_o
);

  localparam int ID_W = clog2(N);

  int   w_k;
  logic w_found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    w_found = 1'b0;
    w_k     = 0;
    for (int i = 0; i < N; i++) begin
      w_k = (int'(ptr_i) + i) % N;
      if (!w_found && req_i[w_k]) begin
        w_found      = 1'b1;
        grant_o[w_k] = 1'b1;
        idx_o        = ID_W'(w_k);
      end
    end
    any_o = w_found;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters, one operation in flight.
// Optional macro ALU_ARB_FIXED_PRIO_EN gives requester 0 absolute priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int OP_W        = OP_W_DEF,
  parameter int ALU_LATENCY = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b_i,
  input  logic [NUM_REQ*OP_W-1:0]     req_op_i,
  output logic                        alu_en_o,
  output logic [DATA_W-1:0]           alu_a_o,
  output logic [DATA_W-1:0]           alu_b_o,
  output logic [OP_W-1:0]             alu_op_o,
  input  logic [DATA_W-1:0]           alu_result_i,
  input  logic                        alu_zero_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [clog2(NUM_REQ)-1:0]   rsp_id_o,
  output logic [DATA_W-1:0]           rsp_result_o,
  output logic                        rsp_zero_o,
  output logic                        busy_o,
  output logic [1:0]                  dbg_state_o
);

  // Handshakes: a request transfers in the cycle req_valid_i[k] & req_ready_o[k];
  // a response transfers in the cycle rsp_valid_o & rsp_ready_i. Neither side
  // may make its valid depend on the other side's ready.

  localparam int ID_W = clog2(NUM_REQ);

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [OP_W-1:0]     r_op;
  logic [1:0]          r_cnt;
  logic                r_en;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_result;
  logic                r_rsp_zero;

  logic [NUM_REQ-1:0]  w_rr_req;
  logic [NUM_REQ-1:0]  w_rr_grant;
  logic [ID_W-1:0]     w_rr_idx;
  logic                w_rr_any;
  logic                w_prio0;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_win;
  logic                w_any;
  logic [ID_W-1:0]     w_ptr_nxt;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_prio0  = req_valid_i[0];
  assign w_rr_req = {req_valid_i[NUM_REQ-1:1], 1'b0};
`else
  assign w_prio0  = 1'b0;
  assign w_rr_req = req_valid_i;
`endif

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i   (w_rr_req),
    .ptr_i   (r_ptr),
    .grant_o (w_rr_grant),
    .idx_o   (w_rr_idx),
    .any_o   (w_rr_any)
  );

  assign w_grant   = w_prio0 ? {{(NUM_REQ-1){1'b0}}, 1'b1} : w_rr_grant;
  assign w_win     = w_prio0 ? '0 : w_rr_idx;
  assign w_any     = w_prio0 | w_rr_any;
  assign w_ptr_nxt = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  // Gated by rst_i so the grant is silent while reset is held.
  assign req_ready_o = (r_state == S_IDLE && !rst_i) ? w_grant : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_id         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_cnt        <= '0;
      r_en         <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a     <= req_a_i[int'(w_win)*DATA_W +: DATA_W];
            r_b     <= req_b_i[int'(w_win)*DATA_W +: DATA_W];
            r_op    <= req_op_i[int'(w_win)*OP_W +: OP_W];
            r_id    <= w_win;
            r_en    <= 1'b1;
            r_state <= S_ISSUE;
            if (!w_prio0) r_ptr <= w_ptr_nxt;
          end
        end
        S_ISSUE: begin
          r_en    <= 1'b0;
          r_cnt   <= 2'(ALU_LATENCY - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_rsp_result <= alu_result_i;
            r_rsp_zero   <= alu_zero_i;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_en_o     = r_en;
  assign alu_a_o      = r_a;
  assign alu_b_o      = r_b;
  assign alu_op_o     = r_op;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_id_o     = r_id;
  assign rsp_result_o = r_rsp_result;
  assign rsp_zero_o   = r_rsp_zero;
  assign busy_o       = (r_state != S_IDLE);
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at ALU_LATENCY=1 and one at 3,
// each driving a small behavioural ALU; inputs are shared between them.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int OW = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N*OW-1:0] req_op;
  logic            rsp_ready;

  logic [N-1:0]  ready1, ready3;
  logic          en1, en3;
  logic [DW-1:0] a1, b1, a3, b3;
  logic [OW-1:0] op1, op3;
  logic [DW-1:0] alu_res1, alu_res3;
  logic          alu_zero1, alu_zero3;
  logic          rsp_valid1, rsp_valid3;
  logic [1:0]    rsp_id1, rsp_id3;
  logic [DW-1:0] rsp_res1, rsp_res3;
  logic          rsp_zero1, rsp_zero3;
  logic          busy1, busy3;
  logic [1:0]    st1, st3;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .ALU_LATENCY(1)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(ready1),
    .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
    .alu_en_o(en1), .alu_a_o(a1), .alu_b_o(b1), .alu_op_o(op1),
    .alu_result_i(alu_res1), .alu_zero_i(alu_zero1),
    .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id1), .rsp_result_o(rsp_res1), .rsp_zero_o(rsp_zero1),
    .busy_o(busy1), .dbg_state_o(st1)
  );

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .ALU_LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(ready3),
    .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
    .alu_en_o(en3), .alu_a_o(a3), .alu_b_o(b3), .alu_op_o(op3),
    .alu_result_i(alu_res3), .alu_zero_i(alu_zero3),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id3), .rsp_result_o(rsp_res3), .rsp_zero_o(rsp_zero3),
    .busy_o(busy3), .dbg_state_o(st3)
  );

  // behavioural ALUs
  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [OW-1:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      default: return a & b;
    endcase
  endfunction

  logic [DW-1:0] p1, p2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_res1 <= '0;
      p1 <= '0;
      p2 <= '0;
      alu_res3 <= '0;
    end else begin
      if (en1) alu_res1 <= alu_f(a1, b1, op1);
      if (en3) p1 <= alu_f(a3, b3, op3);
      p2       <= p1;
      alu_res3 <= p2;
    end
  end
  assign alu_zero1 = (alu_res1 == '0);
  assign alu_zero3 = (alu_res3 == '0);

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [OW-1:0] op);
    req_a[k*DW +: DW]  = a;
    req_b[k*DW +: DW]  = b;
    req_op[k*OW +: OW] = op;
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (ready1 == '0 && n < 20) begin
      tick();
      n++;
    end
  endtask

  // Called in the grant cycle; follows the op to its response and handshake.
  task automatic complete(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [OW-1:0] op, input logic [DW-1:0] exp_res,
                          input logic exp_zero, input string tag);
    int lat;
    tick();
    req_valid = '0;
    check({tag, "_en"}, en1, 1);
    check({tag, "_a"}, a1, a);
    check({tag, "_b"}, b1, b);
    check({tag, "_op"}, op1, op);
    lat = 1;
    while (!rsp_valid1 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, 3);
    check({tag, "_res"}, rsp_res1, exp_res);
    check({tag, "_zero"}, rsp_zero1, exp_zero);
    check({tag, "_id"}, rsp_id1, k);
    tick();
  endtask

  task automatic run_op(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [OW-1:0] op, input logic [DW-1:0] exp_res,
                        input logic exp_zero, input string tag);
    set_req(k, a, b, op);
    req_valid[k] = 1'b1;
    #1;
    wait_grant();
    check({tag, "_grant"}, ready1, 32'd1 << k);
    complete(k, a, b, op, exp_res, exp_zero, tag);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_g;
    int en_cnt;
    int rise;
    logic [DW-1:0] res_at_rise;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    // reset state
    check("rst_ready", ready1, 0);
    check("rst_en", en1, 0);
    check("rst_rsp_valid", rsp_valid1, 0);
    check("rst_busy", busy1, 0);
    check("rst_state", st1, 0);
    rst = 1'b0;
    tick();

    // 1: zero result from r0
    run_op(0, 8'h00, 8'h00, OP_ADD, 8'h00, 1'b1, "t1");

    // 2: r1 add then sub
    run_op(1, 8'h3A, 8'h19, OP_ADD, 8'h53, 1'b0, "t2_add");
    run_op(1, 8'h3A, 8'h19, OP_SUB, 8'h21, 1'b0, "t2_sub");

    // 3: response back-pressure, r0 waits meanwhile
    rsp_ready = 1'b0;
    set_req(2, 8'h0E, 8'h19, OP_SUB);
    req_valid[2] = 1'b1;
    #1;
    wait_grant();
    check("t3_grant", ready1, 4'b0100);
    tick();
    req_valid = '0;
    set_req(0, 8'h05, 8'h03, OP_ADD);
    req_valid[0] = 1'b1;
    begin
      int n;
      n = 0;
      while (!rsp_valid1 && n < 20) begin
        tick();
        n++;
      end
    end
    for (int c = 0; c < 5; c++) begin
      check("t3_hold_valid", rsp_valid1, 1);
      check("t3_hold_res", rsp_res1, 8'hF5);
      check("t3_hold_zero", rsp_zero1, 0);
      check("t3_hold_id", rsp_id1, 2);
      check("t3_no_grant", ready1, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("t3_rsp_clear", rsp_valid1, 0);
    check("t3_next_grant", ready1, 4'b0001);
    complete(0, 8'h05, 8'h03, OP_ADD, 8'h08, 1'b0, "t3_r0");

    // 4: all requesters valid continuously
    pulse_reset();
    for (int k = 0; k < N; k++) set_req(k, 8'(k + 1), 8'h01, OP_ADD);
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      int n;
      wait_grant();
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (g % 4);
`endif
      check("t4_order", ready1, exp_g);
      tick();
      n = 0;
      while (!rsp_valid1 && n < 20) begin
        tick();
        n++;
      end
      check("t4_rsp_valid", rsp_valid1, 1);
      tick();
    end
    req_valid = '0;
    tick();

    // 5: reset during WAIT
    set_req(3, 8'h44, 8'h11, OP_SUB);
    req_valid = 4'b1000;
    #1;
    wait_grant();
    check("t5_grant", ready1, 4'b1000);
    tick();
    req_valid = '0;
    tick();
    check("t5_state_wait", st1, 2);
    rst = 1'b1;
    #1;
    check("t5_rst_en", en1, 0);
    check("t5_rst_a", a1, 0);
    check("t5_rst_busy", busy1, 0);
    check("t5_rst_valid", rsp_valid1, 0);
    check("t5_rst_state", st1, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t5_no_rsp", rsp_valid1, 0);
    end
    set_req(1, 8'h07, 8'h07, OP_SUB);
    req_valid = 4'b1010;
    #1;
    check("t5_ptr_restart", ready1, 4'b0010);
    complete(1, 8'h07, 8'h07, OP_SUB, 8'h00, 1'b1, "t5");

    // 6: ALU_LATENCY=3 instance
    pulse_reset();
    set_req(2, 8'h10, 8'h05, OP_ADD);
    req_valid = 4'b0100;
    #1;
    check("t6_grant", ready3, 4'b0100);
    en_cnt = 0;
    rise = 0;
    res_at_rise = '0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        req_valid = '0;
        check("t6_a", a3, 8'h10);
      end
      if (en3) en_cnt++;
      if (rsp_valid3 && rise == 0) begin
        rise = c;
        res_at_rise = rsp_res3;
      end
    end
    check("t6_en_cycles", en_cnt, 1);
    check("t6_rise", rise, 5);
    check("t6_res", res_at_rise, 8'h15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one RegisteredALU instance between NUM_REQ requesters using a valid/ready request handshake and a tagged response channel. Arbitration is round-robin. Exactly one operation is in flight at a time.
Sits between the requester blocks and the ALU. It drives the ALU's en/a/b/operation inputs and captures the ALU's result/zero outputs after ALU_LATENCY cycles.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, operand/result width; must match ALU width
OP_W, 3, ALU operation code width
ALU_LATENCY, 1, cycles from ALU en-cycle edge to valid result_o (1..4)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
req_valid_i  in  NUM_REQ  request valid, one bit per requester
req_ready_o  out  NUM_REQ  request accepted this cycle (one-hot or zero)
req_a_i  in  NUM_REQ*DATA_W  operand A; requester k occupies slice [k*DATA_W +: DATA_W]
req_b_i  in  NUM_REQ*DATA_W  operand B, packed the same way
req_op_i  in  NUM_REQ*OP_W  operation code, packed the same way
alu_en_o  out  1  ALU enable
alu_a_o  out  DATA_W  ALU operand A
alu_b_o  out  DATA_W  ALU operand B
alu_op_o  out  OP_W  ALU operation
alu_result_i  in  DATA_W  ALU result
alu_zero_i  in  1  ALU zero flag
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted by consumer
rsp_id_o  out  clog2(NUM_REQ)  index of the requester that issued the operation
rsp_result_o  out  DATA_W  captured result
rsp_zero_o  out  1  captured zero flag
busy_o  out  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Encoding is one-hot or binary, implementer's choice.
- Reset (asynchronous, takes effect immediately): state=IDLE, rr_ptr=0. All outputs are 0: req_ready_o, alu_en_o, alu_a_o/b_o/op_o, rsp_*, busy_o.
- IDLE:
  - Grant scans req_valid_i from rr_ptr upward, wrapping modulo NUM_REQ. The first set bit wins.
  - req_ready_o[win]=1 combinationally, in the same cycle.
  - On the clock edge: latch a/b/op/id of the winner, rr_ptr <= win+1 (wrapping NUM_REQ-1 -> 0), go to ISSUE.
  - No valid request: remain in IDLE with all ready bits 0.
- ISSUE (exactly 1 cycle):
  - alu_en_o=1; alu_a_o/b_o/op_o carry the latched values.
  - Load wait counter with ALU_LATENCY-1, go to WAIT.
- WAIT:
  - alu_en_o=0; ALU operand outputs hold their values.
  - Counter at 0: capture alu_result_i/alu_zero_i into rsp_result_o/rsp_zero_o, set rsp_valid_o=1, go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - rsp_valid_o, rsp_id_o, rsp_result_o and rsp_zero_o hold stable until rsp_valid_o & rsp_ready_i.
  - On that handshake: clear rsp_valid_o, go to IDLE.
  - rsp_ready_i is ignored outside RESP.
- Latency: for ALU_LATENCY=1 with rsp_ready_i=1, acceptance in cycle T gives ISSUE in T+1, WAIT in T+2, rsp_valid_o visible from T+3.
- Back-to-back: a new grant happens in the IDLE cycle after the response handshake. No overlap of operations.
- Operands and op codes pass through unmodified. The arbiter does no arithmetic.
- A requester dropping req_valid_i before it is granted loses nothing.
- A request that arrives while the arbiter is busy waits. It is not dropped.
- Reset mid-operation: the in-flight operation is discarded and no response is produced. The ALU shares rst_i.

Optional Feature:
ALU_ARB_FIXED_PRIO_EN
- Defined: requester 0 wins whenever req_valid_i[0]=1 in IDLE, regardless of rr_ptr. Granting requester 0 does not advance rr_ptr. The others are arbitrated round-robin among themselves.
- Undefined: pure round-robin across all requesters, as described above.

Decomposition:
- Package alu_pkg:
  - OP_ADD=3'b010, OP_SUB=3'b110, OP_W, DATA_W defaults.
  - FSM state typedef/localparams.
  - clog2 helper for the id width.
- Sub-module rr_arbiter (req vector + pointer -> one-hot grant + index), combinational. It is reusable by other shared resources.

Test Plan:
1. Reset, then r0 requests a=0x00, b=0x00, op=OP_ADD -> req_ready_o=0001, rsp_valid_o at T+3 with result=0x00, zero=1, id=0.
2. r1 requests 0x3A OP_ADD 0x19, then 0x3A OP_SUB 0x19 -> result=0x53/zero=0, then result=0x21/zero=0, id=1.
3. r2 requests 0x0E OP_SUB 0x19 with rsp_ready_i held 0 for 5 cycles -> rsp fields stable (0xF5, zero=0, id=2). No new grant until the handshake.
4. All four requesters valid continuously -> grant order 0,1,2,3,0. With ALU_ARB_FIXED_PRIO_EN defined, order is 0,0,0... while r0 stays valid.
5. Assert rst_i during WAIT -> outputs 0 immediately, no rsp_valid_o, and the next request is served normally with rr_ptr restarting at 0.
6. ALU_LATENCY=3 with a behavioural ALU model -> alu_en_o is high for exactly 1 cycle, and rsp_valid_o rises 5 cycles after acceptance.
